apb_irq_aggregator: RTL and testbench
=====================================

// Module: apb_irq_aggregator
// PURPOSE
//  Downstream consumer of the APB timer's TIMINT and up to NUM_IRQ-1 other peripheral interrupts.
//  Per line: polarity normalisation, level/edge capture into a pending register, and masking.
//  Drives one registered interrupt to the CPU and reports the highest-priority pending source.
//  Sits on the same APB segment and PCLK as the timer; all inputs are synchronous to PCLK.
// PARAMETERS
//  NUM_IRQ     8        number of interrupt inputs, 1..16; bit 0 is wired to timer TIMINT
//  IN_ACTIVEH  8'hFF    per-line input polarity mask: 1 = active-high, 0 = active-low
//  IRQ_ACTIVEH 1        output polarity: 1 = IRQ active-high, 0 = active-low
// PORTS
//  PCLK     in   1        clock
//  PRESET   in   1        synchronous, active-high reset
//  PSEL     in   1        APB select
//  PENABLE  in   1        APB enable phase
//  PWRITE   in   1        APB write strobe
//  PADDR    in   3 [4:2]  word address
//  PWDATA   in   32       write data
//  PRDATA   out  32       read data
//  IRQ_IN   in   NUM_IRQ  raw interrupt inputs; IRQ_IN[0] = TIMINT
//  IRQ      out  1        aggregated interrupt to CPU
// BEHAVIOUR
//  Normalise: n = IRQ_IN ~^ IN_ACTIVEH, so 1 = asserted. No synchroniser; inputs are PCLK-domain.
//  Registers (PADDR[4:2]); bits >= NUM_IRQ read 0 and ignore writes:
//   0 RAW      RO   n as sampled this cycle
//   1 PENDING  R/W1C; writing 1 clears edge-mode bits only, level-mode bits ignore writes
//   2 ENABLE   RW   per-line mask, reset 0
//   3 MODE     RW   1 = rising-edge capture, 0 = level, reset 0
//   4 HIGHEST  RO   [31] = valid, [3:0] = lowest index with PENDING&ENABLE set; 0 when none
//   5-7        RAZ/WI
//  Write takes effect on the PCLK edge where PSEL&PENABLE&PWRITE=1. No wait states.
//  Read: PRDATA combinational from address when PSEL&~PWRITE, else 32'h0.
//  Edge capture: prev <= n every cycle, reset 0. rise = n & ~prev.
//   - Input already high at reset release counts as a rising edge on the first cycle after reset.
//   - pending_next = (pending & ~w1c) | rise. Set beats clear when both occur in the same cycle.
//  Level mode: pending bit = registered n, so it follows the input with 1-cycle lag.
//  MODE change 1->0: bit becomes level-tracking next cycle. MODE change 0->1: bit clears,
//   then waits for the next rise.
//  IRQ: registered. Asserted iff |(PENDING & ENABLE), then polarity applied.
//  Latency: edge on IRQ_IN at clock n -> PENDING at n+1 -> IRQ at n+2.
//  Reset (PRESET=1 at an edge): PENDING, ENABLE, MODE, prev = 0; IRQ = inactive level (0 if IRQ_ACTIVEH=1).
//  Reset mid-operation discards all pending state; no event is replayed.
// STRUCTURE
//  Package apb_irq_pkg:
//   - register offset localparams (RAW..HIGHEST)
//   - ID_W = 4 and HIGHEST valid-bit position
//   - function priority_enc(input [15:0]) returning {valid, id}
//  Sub-module irq_pending_cell (one per line, generate loop):
//   - holds prev and pending bit
//   - inputs: n, mode, w1c, PCLK, PRESET
//  Top level: APB decode, ENABLE/MODE registers, read mux, priority encode, IRQ output register.
// TESTING
//  1. Reset, ENABLE=1, MODE=1, pulse IRQ_IN[0] for 1 cycle
//     -> PENDING=1 at n+1, IRQ=1 at n+2, HIGHEST=32'h8000_0000.
//  2. Write PENDING=1 while IRQ_IN[0] stays high
//     -> bit clears, IRQ drops 1 cycle later, no re-set without a new rise.
//  3. Issue a W1C on bit 2 in the same cycle a new rise arrives on bit 2
//     -> PENDING[2] stays 1.
//  4. MODE=0, IRQ_IN[3] high, ENABLE=8'h08 -> IRQ=1; W1C has no effect;
//     drop input -> PENDING[3]=0 next cycle, IRQ=0 the cycle after.
//  5. PENDING=8'h28 with ENABLE=8'hFF -> HIGHEST=32'h8000_0003;
//     set ENABLE=8'h20 -> HIGHEST=32'h8000_0005.
//  6. Assert PRESET mid-pending -> all registers read 0, IRQ inactive next cycle;
//     IN_ACTIVEH=0 line held low through reset -> PENDING set 1 cycle after release.

Source files
------------

// File: rtl/apb_irq_aggregator_pkg.sv
// Shared constants and helpers for the APB interrupt aggregator.
package apb_irq_pkg;

  // Register word offsets (PADDR[4:2])
  localparam logic [2:0] REG_RAW     = 3'd0;
  localparam logic [2:0] REG_PENDING = 3'd1;
  localparam logic [2:0] REG_ENABLE  = 3'd2;
  localparam logic [2:0] REG_MODE    = 3'd3;
  localparam logic [2:0] REG_HIGHEST = 3'd4;

  // Source id width and position of the valid flag in HIGHEST
  localparam int ID_W              = 4;
  localparam int HIGHEST_VALID_BIT = 31;

  // Lowest set index wins; returns {valid, id}, all zero when nothing is set.
  function automatic logic [ID_W:0] priority_enc(input logic [15:0] vec);
    logic [ID_W:0] res;
    res = '0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        res = {1'b1, ID_W'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_irq_aggregator_if.sv
// APB slave bus bundle for the interrupt aggregator (PADDR is the word address [4:2]).
interface apb_irq_aggregator_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [4:2]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA
  );
endinterface

// File: rtl/apb_irq_aggregator_cell.sv
// One interrupt line: rising-edge detector plus the pending bit.
// Level mode mirrors the normalised input with one cycle of lag; edge mode
// latches rises and is cleared by W1C, with a simultaneous rise winning.
module irq_pending_cell (
  input  logic PCLK,
  input  logic PRESET,
  input  logic i_n,
  input  logic i_mode,
  input  logic i_w1c,
  output logic o_pending
);

  logic r_prev;
  logic r_mode_d;
  logic r_pending;
  logic w_rise;
  logic w_pending_nxt;

  assign w_rise = i_n & ~r_prev;

  // Next pending value; the first edge-mode cycle after a level->edge switch clears the bit
  always_comb begin
    w_pending_nxt = r_pending;
    if (!i_mode) begin
      w_pending_nxt = i_n;
    end else if (!r_mode_d) begin
      w_pending_nxt = 1'b0;
    end else begin
      w_pending_nxt = (r_pending & ~i_w1c) | w_rise;
    end
  end

  // Edge history, mode history and pending state
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_prev    <= 1'b0;
      r_mode_d  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_prev    <= i_n;
      r_mode_d  <= i_mode;
      r_pending <= w_pending_nxt;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/apb_irq_aggregator.sv
// APB interrupt aggregator: polarity normalisation, per-line capture,
// masking, lowest-index priority report and a registered CPU interrupt.
module apb_irq_aggregator
  import apb_irq_pkg::*;
#(
  parameter int                 NUM_IRQ     = 8,
  parameter logic [NUM_IRQ-1:0] IN_ACTIVEH  = '1,
  parameter bit                 IRQ_ACTIVEH = 1'b1
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_irq_aggregator_if.slave  apb,
  input  logic [NUM_IRQ-1:0]   IRQ_IN,
  output logic                 IRQ
);

  logic [NUM_IRQ-1:0] w_n;
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_pe;
  logic [NUM_IRQ-1:0] r_enable;
  logic [NUM_IRQ-1:0] r_mode;
  logic               w_wr;
  logic [ID_W:0]      w_highest;
  logic [31:0]        w_rdata;
  logic               r_irq;
  logic               w_unused;

  // Inputs are already PCLK-synchronous; 1 = asserted after this
  assign w_n   = IRQ_IN ~^ IN_ACTIVEH;
  assign w_wr  = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign w_w1c = (w_wr && (apb.PADDR == REG_PENDING)) ? apb.PWDATA[NUM_IRQ-1:0] : '0;

  // Upper write-data bits have no storage behind them
  assign w_unused = ^apb.PWDATA;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_cell
    irq_pending_cell u_cell (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .i_n       (w_n[g]),
      .i_mode    (r_mode[g]),
      .i_w1c     (w_w1c[g]),
      .o_pending (w_pending[g])
    );
  end

  assign w_pe      = w_pending & r_enable;
  assign w_highest = priority_enc(16'(w_pe));

  // ENABLE and MODE control registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_enable <= '0;
      r_mode   <= '0;
    end else begin
      if (w_wr && (apb.PADDR == REG_ENABLE)) begin
        r_enable <= apb.PWDATA[NUM_IRQ-1:0];
      end
      if (w_wr && (apb.PADDR == REG_MODE)) begin
        r_mode <= apb.PWDATA[NUM_IRQ-1:0];
      end
    end
  end

  // Registered CPU interrupt with output polarity applied
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_irq <= ~IRQ_ACTIVEH;
    end else begin
      r_irq <= (|w_pe) ~^ IRQ_ACTIVEH;
    end
  end

  assign IRQ = r_irq;

  // Combinational read mux; bus reads zero whenever no read is in progress
  always_comb begin
    w_rdata = 32'h0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (apb.PADDR)
        REG_RAW:     w_rdata = 32'(w_n);
        REG_PENDING: w_rdata = 32'(w_pending);
        REG_ENABLE:  w_rdata = 32'(r_enable);
        REG_MODE:    w_rdata = 32'(r_mode);
        REG_HIGHEST: w_rdata = {w_highest[ID_W], {(HIGHEST_VALID_BIT-ID_W){1'b0}},
                                w_highest[ID_W-1:0]};
        default:     w_rdata = 32'h0;
      endcase
    end else begin
      w_rdata = 32'h0;
    end
  end

  assign apb.PRDATA = w_rdata;

endmodule

// File: tb/tb_apb_irq_aggregator.sv
// Directed bench for apb_irq_aggregator; line 7 is configured active-low.
module tb_apb_irq_aggregator;
  import apb_irq_pkg::*;

  localparam int NUM_IRQ = 8;
  localparam logic [7:0] IDLE_IN = 8'h80;

  logic       PCLK;
  logic       PRESET;
  logic [7:0] IRQ_IN;
  logic       IRQ;
  int         n_vec;
  int         n_miss;

  apb_irq_aggregator_if apb_bus ();

  apb_irq_aggregator #(
    .NUM_IRQ     (NUM_IRQ),
    .IN_ACTIVEH  (8'h7F),
    .IRQ_ACTIVEH (1'b1)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .apb    (apb_bus),
    .IRQ_IN (IRQ_IN),
    .IRQ    (IRQ)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apb_read(input logic [2:0] addr, output logic [31:0] data);
    apb_bus.PSEL    = 1'b1;
    apb_bus.PENABLE = 1'b1;
    apb_bus.PWRITE  = 1'b0;
    apb_bus.PADDR   = addr;
    #1;
    data = apb_bus.PRDATA;
    apb_bus.PSEL    = 1'b0;
    apb_bus.PENABLE = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    apb_read(addr, rd);
    check_value(tag, rd, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check_value(tag, {31'h0, IRQ}, {31'h0, exp});
  endtask

  // Setup phase, then access phase; IRQ_IN takes irq_val during the access phase
  task automatic apb_write_irq(input logic [2:0] addr, input logic [31:0] data, input logic [7:0] irq_val);
    apb_bus.PSEL    = 1'b1;
    apb_bus.PENABLE = 1'b0;
    apb_bus.PWRITE  = 1'b1;
    apb_bus.PADDR   = addr;
    apb_bus.PWDATA  = data;
    tick();
    apb_bus.PENABLE = 1'b1;
    IRQ_IN          = irq_val;
    tick();
    apb_bus.PSEL    = 1'b0;
    apb_bus.PENABLE = 1'b0;
    apb_bus.PWRITE  = 1'b0;
  endtask

  task automatic apb_write(input logic [2:0] addr, input logic [31:0] data);
    apb_write_irq(addr, data, IRQ_IN);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    PRESET = 1'b1;
    IRQ_IN = IDLE_IN;
    apb_bus.PSEL    = 1'b0;
    apb_bus.PENABLE = 1'b0;
    apb_bus.PWRITE  = 1'b0;
    apb_bus.PADDR   = 3'd0;
    apb_bus.PWDATA  = 32'h0;
    tick(); tick(); tick();

    // Reset state
    check_irq("rst_irq", 1'b0);
    check_reg("rst_raw", REG_RAW, 32'h0);
    check_reg("rst_pending", REG_PENDING, 32'h0);
    check_reg("rst_enable", REG_ENABLE, 32'h0);
    check_reg("rst_mode", REG_MODE, 32'h0);
    check_reg("rst_highest", REG_HIGHEST, 32'h0);
    PRESET = 1'b0;
    tick();

    // 1: edge capture of a one-cycle pulse on line 0
    apb_write(REG_ENABLE, 32'h01);
    apb_write(REG_MODE, 32'h01);
    tick();
    IRQ_IN = 8'h81;
    tick();
    IRQ_IN = IDLE_IN;
    check_reg("t1_pending", REG_PENDING, 32'h01);
    check_irq("t1_irq_lag", 1'b0);
    tick();
    check_irq("t1_irq", 1'b1);
    check_reg("t1_highest", REG_HIGHEST, 32'h8000_0000);

    // 2: W1C while the input stays high; no re-set without a new rise
    IRQ_IN = 8'h81;
    tick();
    apb_write(REG_PENDING, 32'h01);
    check_reg("t2_pending_clr", REG_PENDING, 32'h0);
    check_irq("t2_irq_hold", 1'b1);
    tick();
    check_irq("t2_irq_drop", 1'b0);
    tick(); tick();
    check_reg("t2_no_reset", REG_PENDING, 32'h0);
    IRQ_IN = IDLE_IN;

    // 3: set beats clear on line 2
    apb_write(REG_MODE, 32'h05);
    tick();
    IRQ_IN = 8'h84;
    tick();
    IRQ_IN = IDLE_IN;
    tick();
    check_reg("t3_pending", REG_PENDING, 32'h04);
    apb_write_irq(REG_PENDING, 32'h04, 8'h84);
    check_reg("t3_set_wins", REG_PENDING, 32'h04);
    apb_write(REG_PENDING, 32'h04);
    check_reg("t3_w1c", REG_PENDING, 32'h0);
    IRQ_IN = IDLE_IN;

    // 4: level mode on line 3
    apb_write(REG_MODE, 32'h00);
    apb_write(REG_ENABLE, 32'h08);
    IRQ_IN = 8'h88;
    tick();
    check_reg("t4_pending", REG_PENDING, 32'h08);
    check_irq("t4_irq_lag", 1'b0);
    tick();
    check_irq("t4_irq", 1'b1);
    apb_write(REG_PENDING, 32'h08);
    check_reg("t4_w1c_ignored", REG_PENDING, 32'h08);
    IRQ_IN = IDLE_IN;
    tick();
    check_reg("t4_pending_drop", REG_PENDING, 32'h0);
    check_irq("t4_irq_still", 1'b1);
    tick();
    check_irq("t4_irq_drop", 1'b0);

    // 5: priority report and register boundaries
    apb_write(REG_ENABLE, 32'hFF);
    IRQ_IN = 8'hA8;
    tick();
    check_reg("t5_raw", REG_RAW, 32'h28);
    check_reg("t5_pending", REG_PENDING, 32'h28);
    check_reg("t5_highest3", REG_HIGHEST, 32'h8000_0003);
    apb_write(REG_ENABLE, 32'h20);
    check_reg("t5_highest5", REG_HIGHEST, 32'h8000_0005);
    apb_write(REG_ENABLE, 32'h00);
    check_reg("t5_highest_none", REG_HIGHEST, 32'h0);
    apb_write(REG_ENABLE, 32'hFFFF_FFFF);
    check_reg("t5_enable_width", REG_ENABLE, 32'h0000_00FF);
    apb_write(3'd6, 32'hFFFF_FFFF);
    check_reg("t5_raz5", 3'd5, 32'h0);
    check_reg("t5_raz6", 3'd6, 32'h0);
    tick();
    check_irq("t5_irq", 1'b1);

    // 6: reset mid-pending, active-low line held asserted through reset
    PRESET = 1'b1;
    IRQ_IN = 8'h00;
    tick();
    check_irq("t6_irq_rst", 1'b0);
    check_reg("t6_pending_rst", REG_PENDING, 32'h0);
    check_reg("t6_enable_rst", REG_ENABLE, 32'h0);
    check_reg("t6_mode_rst", REG_MODE, 32'h0);
    tick();
    PRESET = 1'b0;
    check_reg("t6_pending_rel", REG_PENDING, 32'h0);
    tick();
    check_reg("t6_pending_set", REG_PENDING, 32'h80);
    check_reg("t6_raw", REG_RAW, 32'h80);
    check_irq("t6_irq_masked", 1'b0);
    apb_write(REG_ENABLE, 32'h80);
    check_reg("t6_highest7", REG_HIGHEST, 32'h8000_0007);
    tick();
    check_irq("t6_irq", 1'b1);

    // Level -> edge switch clears the bit and waits for a fresh rise
    apb_write(REG_MODE, 32'h80);
    tick(); tick();
    check_reg("t7_mode_clear", REG_PENDING, 32'h0);
    check_irq("t7_irq_drop", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
